// File: rtl/vlx_pkg.sv
// Shared types and constants for the VLX byte-store scheduler.
// The 0xFF/0x00 byte stuffing path is only built when VLX_BYTE_STUFF_EN is defined.
package vlx_pkg;

  // Scheduler FSM states. STUFF is only entered when byte stuffing is compiled in.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARB   = 2'd1,
    DATA  = 2'd2,
    STUFF = 2'd3
  } vlx_state_t;

  // A byte equal to the mark is followed on the bus by the stuff byte.
  localparam logic [7:0] VLX_STUFF_MARK = 8'hFF;
  localparam logic [7:0] VLX_STUFF_BYTE = 8'h00;

  // Big-endian byte lane: address offset 0 lands on the most significant lane.
  function automatic logic [3:0] vlx_lane_sel(input logic [1:0] offset);
    return 4'b1000 >> offset;
  endfunction

endpackage

// File: rtl/vlx_byte_fifo.sv
// Small byte FIFO between the VLX bit packer and the store scheduler.
// A push while full is accepted only when a pop happens in the same cycle.
module vlx_byte_fifo
  import vlx_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push,
  input  logic                     pop,
  input  logic [7:0]               wdata,
  output logic [7:0]               head,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (level == '0);
  assign full    = (level == LW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  // Storage array; contents need no reset because level gates every read.
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/vlx_store_sched.sv
// VLX byte-store scheduler: buffers packed JPEG bytes, arbitrates for the data
// bus and writes them one byte per Wishbone classic cycle at an incrementing
// big-endian address. Define VLX_BYTE_STUFF_EN to insert 0x00 after every 0xFF.
module vlx_store_sched
  import vlx_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [7:0]               byte_i,
  output logic                     full_o,
  input  logic                     addr_set_i,
  input  logic [31:0]              addr_i,
  output logic [31:0]              addr_o,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic                     busy_o,
  output logic                     ovf_o,
  output logic                     err_o,
  output logic                     bus_req_o,
  input  logic                     bus_gnt_i,
  output logic                     wb_cyc_o,
  output logic                     wb_stb_o,
  output logic                     wb_we_o,
  output logic [31:0]              wb_adr_o,
  output logic [31:0]              wb_dat_o,
  output logic [3:0]               wb_sel_o,
  input  logic                     wb_ack_i,
  input  logic                     wb_err_i
);

  localparam int LW = $clog2(DEPTH) + 1;

  vlx_state_t state;
  vlx_state_t state_nxt;

  logic [31:0]   addr_q;
  logic [7:0]    fifo_head;
  logic [LW-1:0] fifo_level;
  logic          fifo_full;
  logic          fifo_empty;
  logic          in_data;
  logic          in_stuff;
  logic          xfer;
  logic          xfer_nxt;
  logic          bus_done;
  logic          pop;
  logic          more_after_pop;
  logic          drop;

  vlx_byte_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .push  (push_i),
    .pop   (pop),
    .wdata (byte_i),
    .head  (fifo_head),
    .level (fifo_level),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign in_data = (state == DATA);
`ifdef VLX_BYTE_STUFF_EN
  assign in_stuff = (state == STUFF);
  assign xfer_nxt = (state_nxt == DATA) || (state_nxt == STUFF);
`else
  assign in_stuff = 1'b0;
  assign xfer_nxt = (state_nxt == DATA);
`endif
  assign xfer = in_data || in_stuff;

  // An error response consumes the byte exactly like an ack does.
  assign bus_done       = xfer && (wb_ack_i || wb_err_i);
  assign pop            = in_data && bus_done;
  assign more_after_pop = (fifo_level > LW'(1)) || push_i;
  assign drop           = push_i && fifo_full && !pop;

  assign full_o  = fifo_full;
  assign level_o = fifo_level;
  assign addr_o  = addr_q;
  assign busy_o  = !fifo_empty || (state != IDLE);

  // Next-state selection for the scheduler FSM.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          state_nxt = ARB;
        end
      end
      ARB: begin
        if (bus_gnt_i) begin
          state_nxt = DATA;
        end
      end
      DATA: begin
        if (bus_done) begin
`ifdef VLX_BYTE_STUFF_EN
          if (fifo_head == VLX_STUFF_MARK) begin
            state_nxt = STUFF;
          end else
`endif
          state_nxt = more_after_pop ? DATA : IDLE;
        end
      end
`ifdef VLX_BYTE_STUFF_EN
      STUFF: begin
        if (bus_done) begin
          state_nxt = (!fifo_empty || push_i) ? DATA : IDLE;
        end
      end
`endif
      default: state_nxt = IDLE;
    endcase
  end

  // State register plus registered bus controls; async reset drops the cycle at once.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state     <= IDLE;
      bus_req_o <= 1'b0;
      wb_cyc_o  <= 1'b0;
      wb_stb_o  <= 1'b0;
      wb_we_o   <= 1'b0;
    end else begin
      state     <= state_nxt;
      bus_req_o <= (state_nxt != IDLE);
      wb_cyc_o  <= xfer_nxt;
      wb_stb_o  <= xfer_nxt;
      wb_we_o   <= xfer_nxt;
    end
  end

  // Write address: loaded by software only while idle, advanced per completed byte.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      addr_q <= '0;
    end else if (addr_set_i && !busy_o) begin
      addr_q <= addr_i;
    end else if (bus_done) begin
      addr_q <= addr_q + 32'd1;
    end
  end

  // Sticky overflow and bus-error flags, cleared by an accepted address load.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ovf_o <= 1'b0;
      err_o <= 1'b0;
    end else if (addr_set_i && !busy_o) begin
      ovf_o <= 1'b0;
      err_o <= 1'b0;
    end else begin
      if (drop) begin
        ovf_o <= 1'b1;
      end
      if (xfer && wb_err_i) begin
        err_o <= 1'b1;
      end
    end
  end

  // Wishbone address/data/select are zero outside a transfer.
  always_comb begin
    wb_adr_o = '0;
    wb_sel_o = '0;
    wb_dat_o = '0;
    if (xfer) begin
      wb_adr_o = addr_q;
      wb_sel_o = vlx_lane_sel(addr_q[1:0]);
    end
    if (in_data) begin
      wb_dat_o = {4{fifo_head}};
    end else if (in_stuff) begin
      wb_dat_o = {4{VLX_STUFF_BYTE}};
    end
  end

endmodule

// File: tb/tb_vlx_store_sched.sv
// Self-checking bench for vlx_store_sched. Expected bus writes are queued when
// bytes are pushed and compared by a bus responder as each write is acked.
// Expectations follow VLX_BYTE_STUFF_EN when it is defined for the build.
module tb_vlx_store_sched;

  localparam int DEPTH = 4;
  localparam int LW    = $clog2(DEPTH) + 1;

`ifdef VLX_BYTE_STUFF_EN
  localparam bit STUFF_ON = 1'b1;
`else
  localparam bit STUFF_ON = 1'b0;
`endif

  typedef struct packed {
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
  } wr_t;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic          push_i = 1'b0;
  logic [7:0]    byte_i = 8'h00;
  logic          full_o;
  logic          addr_set_i = 1'b0;
  logic [31:0]   addr_i = 32'h0;
  logic [31:0]   addr_o;
  logic [LW-1:0] level_o;
  logic          busy_o;
  logic          ovf_o;
  logic          err_o;
  logic          bus_req_o;
  logic          bus_gnt_i = 1'b0;
  logic          wb_cyc_o;
  logic          wb_stb_o;
  logic          wb_we_o;
  logic [31:0]   wb_adr_o;
  logic [31:0]   wb_dat_o;
  logic [3:0]    wb_sel_o;
  logic          wb_ack_i = 1'b0;
  logic          wb_err_i = 1'b0;

  wr_t         sb[$];
  int          compared   = 0;
  int          mismatched = 0;
  logic [31:0] exp_addr   = 32'h0;
  bit          ack_en     = 1'b1;
  bit          err_next   = 1'b0;

  vlx_store_sched #(
    .DEPTH (DEPTH)
  ) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .push_i     (push_i),
    .byte_i     (byte_i),
    .full_o     (full_o),
    .addr_set_i (addr_set_i),
    .addr_i     (addr_i),
    .addr_o     (addr_o),
    .level_o    (level_o),
    .busy_o     (busy_o),
    .ovf_o      (ovf_o),
    .err_o      (err_o),
    .bus_req_o  (bus_req_o),
    .bus_gnt_i  (bus_gnt_i),
    .wb_cyc_o   (wb_cyc_o),
    .wb_stb_o   (wb_stb_o),
    .wb_we_o    (wb_we_o),
    .wb_adr_o   (wb_adr_o),
    .wb_dat_o   (wb_dat_o),
    .wb_sel_o   (wb_sel_o),
    .wb_ack_i   (wb_ack_i),
    .wb_err_i   (wb_err_i)
  );

  // Free-running clock.
  always #5 clk_i = ~clk_i;

  // Global time limit so the bench can never hang.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    compared++;
    if (obs !== expv) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, obs, expv);
    end
  endtask

  task automatic queueWrite(input logic [31:0] a, input logic [7:0] b);
    wr_t w;
    w.adr = a;
    w.dat = {4{b}};
    w.sel = 4'b1000 >> a[1:0];
    sb.push_back(w);
  endtask

  // Drives one push for one clock; called at a falling edge, returns at the next.
  task automatic applyStimulus(input logic [7:0] b, input bit accept);
    push_i = 1'b1;
    byte_i = b;
    if (accept) begin
      queueWrite(exp_addr, b);
      exp_addr = exp_addr + 32'd1;
      if (STUFF_ON && b == 8'hFF) begin
        queueWrite(exp_addr, 8'h00);
        exp_addr = exp_addr + 32'd1;
      end
    end
    @(negedge clk_i);
    push_i = 1'b0;
  endtask

  task automatic setAddr(input logic [31:0] a);
    addr_set_i = 1'b1;
    addr_i     = a;
    exp_addr   = a;
    @(negedge clk_i);
    addr_set_i = 1'b0;
  endtask

  task automatic waitIdle(input int max_cycles, input string tag);
    for (int i = 0; i < max_cycles; i++) begin
      if (!busy_o) break;
      @(negedge clk_i);
    end
    checkOutput({tag, " busy"}, 32'(busy_o), 32'd0);
    checkOutput({tag, " pending writes"}, 32'(sb.size()), 32'd0);
  endtask

  task automatic waitCyc(input int max_cycles, input string tag);
    for (int i = 0; i < max_cycles; i++) begin
      if (wb_cyc_o) break;
      @(negedge clk_i);
    end
    checkOutput({tag, " cyc"}, 32'(wb_cyc_o), 32'd1);
  endtask

  // Bus slave: on each falling edge with an active strobe, check the write and respond.
  initial begin
    wr_t w;
    forever begin
      @(negedge clk_i);
      if (!rst_i && wb_cyc_o && wb_stb_o && ack_en) begin
        if (sb.size() == 0) begin
          checkOutput("unexpected write adr", wb_adr_o, 32'hFFFF_FFFF);
        end else begin
          w = sb.pop_front();
          checkOutput("write adr", wb_adr_o, w.adr);
          checkOutput("write dat", wb_dat_o, w.dat);
          checkOutput("write sel", 32'(wb_sel_o), 32'(w.sel));
          checkOutput("write we", 32'(wb_we_o), 32'd1);
        end
        if (err_next) begin
          wb_err_i = 1'b1;
          wb_ack_i = 1'b0;
          err_next = 1'b0;
        end else begin
          wb_ack_i = 1'b1;
          wb_err_i = 1'b0;
        end
      end else begin
        wb_ack_i = 1'b0;
        wb_err_i = 1'b0;
      end
    end
  end

  // Main test sequence.
  initial begin
    rst_i = 1'b1;
    repeat (2) @(negedge clk_i);
    checkOutput("reset addr", addr_o, 32'h0);
    checkOutput("reset level", 32'(level_o), 32'd0);
    checkOutput("reset busy", 32'(busy_o), 32'd0);
    checkOutput("reset cyc", 32'(wb_cyc_o), 32'd0);
    checkOutput("reset req", 32'(bus_req_o), 32'd0);
    checkOutput("reset wb_adr", wb_adr_o, 32'h0);
    checkOutput("reset wb_dat", wb_dat_o, 32'h0);
    checkOutput("reset wb_sel", 32'(wb_sel_o), 32'd0);
    checkOutput("reset flags", {30'd0, ovf_o, err_o}, 32'd0);
    rst_i = 1'b0;
    @(negedge clk_i);

    // Two plain bytes with immediate grant.
    setAddr(32'h0000_1000);
    checkOutput("t1 addr loaded", addr_o, 32'h0000_1000);
    bus_gnt_i = 1'b1;
    applyStimulus(8'h12, 1'b1);
    checkOutput("t1 level after push", 32'(level_o), 32'd1);
    checkOutput("t1 busy after push", 32'(busy_o), 32'd1);
    applyStimulus(8'h34, 1'b1);
    waitIdle(40, "t1");
    checkOutput("t1 final addr", addr_o, 32'h0000_1002);

    // Marker byte followed by a normal byte at a misaligned start.
    setAddr(32'h0000_2003);
    applyStimulus(8'hFF, 1'b1);
    applyStimulus(8'hAB, 1'b1);
    waitIdle(40, "t2");
    checkOutput("t2 final addr", addr_o, STUFF_ON ? 32'h0000_2006 : 32'h0000_2005);

    // Overflow with the grant withheld.
    setAddr(32'h0000_3000);
    bus_gnt_i = 1'b0;
    applyStimulus(8'h01, 1'b1);
    applyStimulus(8'h02, 1'b1);
    applyStimulus(8'h03, 1'b1);
    applyStimulus(8'h04, 1'b1);
    applyStimulus(8'h05, 1'b0);
    checkOutput("t3 full", 32'(full_o), 32'd1);
    checkOutput("t3 ovf", 32'(ovf_o), 32'd1);
    checkOutput("t3 level", 32'(level_o), 32'd4);
    repeat (5) @(negedge clk_i);
    checkOutput("t3 req while waiting", 32'(bus_req_o), 32'd1);
    checkOutput("t3 no cyc without grant", 32'(wb_cyc_o), 32'd0);
    bus_gnt_i = 1'b1;
    waitIdle(40, "t3");
    checkOutput("t3 final addr", addr_o, 32'h0000_3004);

    // Push while full with a pop in the same cycle.
    setAddr(32'h0000_3100);
    checkOutput("t4 ovf cleared", 32'(ovf_o), 32'd0);
    bus_gnt_i = 1'b0;
    ack_en    = 1'b0;
    applyStimulus(8'h21, 1'b1);
    applyStimulus(8'h22, 1'b1);
    applyStimulus(8'h23, 1'b1);
    applyStimulus(8'h24, 1'b1);
    checkOutput("t4 full", 32'(full_o), 32'd1);
    bus_gnt_i = 1'b1;
    @(negedge clk_i);
    waitCyc(20, "t4");
    #1 ack_en = 1'b1;
    @(negedge clk_i);
    checkOutput("t4 level before", 32'(level_o), 32'd4);
    push_i = 1'b1;
    byte_i = 8'h5A;
    queueWrite(32'h0000_3104, 8'h5A);
    @(negedge clk_i);
    push_i = 1'b0;
    checkOutput("t4 level after", 32'(level_o), 32'd4);
    checkOutput("t4 ovf", 32'(ovf_o), 32'd0);
    waitIdle(40, "t4");
    checkOutput("t4 final addr", addr_o, 32'h0000_3105);

    // Bus error on the first of two bytes.
    setAddr(32'h0000_4000);
    err_next = 1'b1;
    applyStimulus(8'h11, 1'b1);
    applyStimulus(8'h22, 1'b1);
    waitIdle(40, "t5");
    checkOutput("t5 err", 32'(err_o), 32'd1);
    checkOutput("t5 final addr", addr_o, 32'h0000_4002);
    setAddr(32'h0000_5000);
    checkOutput("t5 err cleared", 32'(err_o), 32'd0);
    checkOutput("t5 addr loaded", addr_o, 32'h0000_5000);

    // Address wraps from all-ones to zero.
    setAddr(32'hFFFF_FFFF);
    applyStimulus(8'h01, 1'b1);
    applyStimulus(8'h02, 1'b1);
    waitIdle(40, "t6");
    checkOutput("t6 wrapped addr", addr_o, 32'h0000_0001);

    // Reset in the middle of a data cycle.
    setAddr(32'h0000_6000);
    ack_en = 1'b0;
    applyStimulus(8'h77, 1'b1);
    applyStimulus(8'h78, 1'b1);
    waitCyc(20, "t7");
    #2 rst_i = 1'b1;
    #1;
    checkOutput("t7 cyc async drop", 32'(wb_cyc_o), 32'd0);
    checkOutput("t7 level", 32'(level_o), 32'd0);
    checkOutput("t7 addr", addr_o, 32'h0);
    checkOutput("t7 req", 32'(bus_req_o), 32'd0);
    sb.delete();
    @(negedge clk_i);
    rst_i  = 1'b0;
    ack_en = 1'b1;
    @(negedge clk_i);
    checkOutput("t7 busy after reset", 32'(busy_o), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
